v_pipe_update_cmp_pl: RTL and testbench
=======================================

Name: v_pipe_update_cmp_pl

Overview:
- Pipelined, parametrised successor to the single-cycle update comparator.
- Compares a command key against a snapshot of the current table state and returns match, full/empty, mask and position results.
- Sits between the update-pipe command issue stage and the table writeback stage.
- Adds over the previous generation:
  - parametrised depth and key width;
  - per-command bid/ask mode instead of a build-time table type;
  - two register stages with valid/ready backpressure;
  - flush, encoded position, occupancy and duplicate-key error outputs.

Parameters:
ENTRIES_N, 16, number of table entries (>=2).
KEY_W, 32, key width in bits.
POS_W, $clog2(ENTRIES_N+1), width of position/count outputs (derived; do not override).

Ports:
clk  in  1  clock; all state on rising edge.
arst_n  in  1  reset, asynchronous assert, active-low.
i_vld  in  1  command valid.
o_rdy  out  1  command accepted when i_vld & o_rdy.
i_is_bid  in  1  1 = bid table (ordering descending), 0 = ask table (ordering ascending).
i_key  in  KEY_W  command key.
i_stcur_vld  in  ENTRIES_N  entry valid vector (unary, contiguous from index 0).
i_stcur_keys  in  ENTRIES_N*KEY_W  entry keys; entry i occupies bits [i*KEY_W +: KEY_W].
i_flush  in  1  discard all in-flight commands.
o_vld  out  1  result valid.
i_rdy  in  1  downstream ready.
o_hit  out  1  a valid entry key equals i_key.
o_full  out  1  all entries valid.
o_empty  out  1  no entries valid.
o_sel  out  ENTRIES_N  one-hot (or zero) matching-entry vector.
o_mask  out  ENTRIES_N  valid entries at-or-better than i_key.
o_pos  out  POS_W  popcount(o_mask & ~o_sel): insert index on miss, match index on hit.
o_cnt  out  POS_W  popcount(i_stcur_vld).
o_err_dup  out  1  more than one entry matched (table-integrity error).

Behaviour:
- Stage S1 on accept: registers key, mode, valid vector and keys; sets s1_vld.
- Stage S2: computes all results combinationally from S1 and registers them; sets s2_vld.
- All outputs are driven from S2 registers, with no combinational path from inputs.
- Latency: a command accepted at cycle T presents o_vld at T+2 when i_rdy is held high.
- Throughput: one command per cycle.
- Ready chain:
  - s2_adv = !s2_vld | i_rdy;
  - s1_adv = !s1_vld | s2_adv;
  - o_rdy = s1_adv & !i_flush.
- Stall: when o_vld & !i_rdy, S2 holds all outputs stable. S1 then holds if occupied, and o_rdy drops once S1 is full.
- Mask definition, per entry i (vld = captured i_stcur_vld):
  - eq_i = (keys_i == key);
  - bid: o_mask[i] = vld[i] & (keys_i >= key);
  - ask: o_mask[i] = vld[i] & (keys_i <= key);
  - all comparisons are unsigned over KEY_W bits.
- o_sel[i] = vld[i] & eq_i.
- o_hit = |o_sel.
- o_full = &vld.
- o_empty = ~|vld.
- o_err_dup = popcount(o_sel) > 1. o_sel, o_hit and o_pos are still reported unmodified when o_err_dup is set.
- Invalid entries never contribute to o_sel or o_mask, regardless of key contents.
- o_pos range is 0..ENTRIES_N. o_pos = ENTRIES_N only when the table is full and the command ranks worst (miss). Downstream treats full & !hit with o_pos==ENTRIES_N as a drop.
- Flush:
  - i_flush clears s1_vld and s2_vld on the next edge;
  - o_rdy is 0 during the flush cycle, so no input is accepted that cycle;
  - o_vld is 0 the cycle after flush;
  - flush overrides stall.
- Reset (arst_n low): s1_vld = s2_vld = 0 and every registered output = 0 (o_vld, o_hit, o_full, o_empty, o_sel, o_mask, o_pos, o_cnt, o_err_dup).
  - o_rdy = 1 while out of reset with no flush.
  - Reset mid-operation drops in-flight commands with no output.
- Datapath registers need not reset, but the outputs above must read 0 under reset.
- Assertions (simulation only):
  - i_stcur_vld is contiguous from bit 0;
  - o_sel is one-hot or zero when !o_err_dup;
  - outputs are stable while o_vld & !i_rdy.

Test Plan:
1. N=4, KEY_W=8, vld=0111, keys[0..2]=30,20,10, bid, key=20 -> at T+2: hit=1, sel=0010, mask=0011, pos=1, cnt=3, full=0, empty=0.
2. Same state, ask mode, keys=10,20,30, key=25 -> hit=0, sel=0000, mask=0011, pos=2.
3. vld=1111, bid, keys=40,30,20,10, key=5 -> full=1, hit=0, mask=1111, pos=4; vld=0000, key=7 -> empty=1, mask=0000, pos=0, cnt=0.
4. Back-to-back 8 commands with i_rdy low for 3 cycles mid-stream:
   - o_rdy falls after 2 outstanding commands;
   - outputs stay stable while stalled;
   - all 8 results emerge in order, none lost or duplicated.
5. Flush asserted with both stages occupied and i_vld=1:
   - o_rdy=0 that cycle;
   - o_vld=0 next cycle;
   - the next command accepted produces a result exactly 2 cycles later.
6. Duplicate keys vld=0011, keys=15,15, key=15 -> err_dup=1, sel=0011, hit=1.
   - Also assert arst_n mid-stream: all outputs read 0 immediately and o_vld stays 0 until a new command is accepted.

Source files
------------

// File: rtl/v_pipe_update_cmp_pl_if.sv
// Command/result bundle for the two-stage update comparator.
// Handshake: a command transfers on a rising edge with i_vld & o_rdy, and a result transfers with o_vld & i_rdy.
// A sender holds its payload stable from asserting valid until the transfer.
interface v_pipe_update_cmp_pl_if #(
    parameter int ENTRIES_N = 16,
    parameter int KEY_W     = 32
);
    localparam int POS_W = $clog2(ENTRIES_N + 1);

    logic                       i_vld;
    logic                       o_rdy;
    logic                       i_is_bid;
    logic [KEY_W-1:0]           i_key;
    logic [ENTRIES_N-1:0]       i_stcur_vld;
    logic [ENTRIES_N*KEY_W-1:0] i_stcur_keys;
    logic                       i_flush;
    logic                       o_vld;
    logic                       i_rdy;
    logic                       o_hit;
    logic                       o_full;
    logic                       o_empty;
    logic [ENTRIES_N-1:0]       o_sel;
    logic [ENTRIES_N-1:0]       o_mask;
    logic [POS_W-1:0]           o_pos;
    logic [POS_W-1:0]           o_cnt;
    logic                       o_err_dup;

    modport slave (
        input  i_vld, i_is_bid, i_key, i_stcur_vld, i_stcur_keys, i_flush, i_rdy,
        output o_rdy, o_vld, o_hit, o_full, o_empty, o_sel, o_mask, o_pos, o_cnt, o_err_dup
    );

    modport master (
        output i_vld, i_is_bid, i_key, i_stcur_vld, i_stcur_keys, i_flush, i_rdy,
        input  o_rdy, o_vld, o_hit, o_full, o_empty, o_sel, o_mask, o_pos, o_cnt, o_err_dup
    );
endinterface

// File: rtl/v_pipe_update_cmp_pl.sv
// Two-stage update comparator: S1 captures the command and table snapshot.
// S2 registers the match, mask and position results that drive every output.
module v_pipe_update_cmp_pl #(
    parameter int ENTRIES_N = 16,
    parameter int KEY_W     = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    v_pipe_update_cmp_pl_if.slave bus
);
    localparam int POS_W = $clog2(ENTRIES_N + 1);

    logic                       s1_vld;
    logic                       s2_vld;
    logic                       s1_adv;
    logic                       s2_adv;
    logic                       accept;

    logic                       s1_is_bid;
    logic [KEY_W-1:0]           s1_key;
    logic [ENTRIES_N-1:0]       s1_stvld;
    logic [ENTRIES_N*KEY_W-1:0] s1_keys;

    logic [ENTRIES_N-1:0]       sel_c;
    logic [ENTRIES_N-1:0]       mask_c;
    logic [POS_W-1:0]           pos_c;
    logic [POS_W-1:0]           cnt_c;
    logic [POS_W-1:0]           sel_cnt_c;

    logic                       s2_hit;
    logic                       s2_full;
    logic                       s2_empty;
    logic [ENTRIES_N-1:0]       s2_sel;
    logic [ENTRIES_N-1:0]       s2_mask;
    logic [POS_W-1:0]           s2_pos;
    logic [POS_W-1:0]           s2_cnt;
    logic                       s2_err;

    function automatic logic [POS_W-1:0] popcnt(input logic [ENTRIES_N-1:0] v);
        logic [POS_W-1:0] n;
        n = '0;
        for (int i = 0; i < ENTRIES_N; i++) begin
            n = n + POS_W'(v[i]);
        end
        return n;
    endfunction

    assign s2_adv     = !s2_vld || bus.i_rdy;
    assign s1_adv     = !s1_vld || s2_adv;
    assign bus.o_rdy  = s1_adv && !bus.i_flush;
    assign accept     = bus.i_vld && bus.o_rdy;

    // Flush wins over stall: both stages empty on the next edge regardless of i_rdy.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else if (bus.i_flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (s1_adv) s1_vld <= bus.i_vld;
            if (s2_adv) s2_vld <= s1_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_is_bid <= bus.i_is_bid;
            s1_key    <= bus.i_key;
            s1_stvld  <= bus.i_stcur_vld;
            s1_keys   <= bus.i_stcur_keys;
        end
    end

    always_comb begin
        sel_c  = '0;
        mask_c = '0;
        for (int i = 0; i < ENTRIES_N; i++) begin
            sel_c[i]  = s1_stvld[i] && (s1_keys[i*KEY_W +: KEY_W] == s1_key);
            mask_c[i] = s1_stvld[i] && (s1_is_bid ? (s1_keys[i*KEY_W +: KEY_W] >= s1_key)
                                                  : (s1_keys[i*KEY_W +: KEY_W] <= s1_key));
        end
    end

    // Entries strictly better than the key: insert slot on a miss, match slot on a hit.
    assign pos_c     = popcnt(mask_c & ~sel_c);
    assign cnt_c     = popcnt(s1_stvld);
    assign sel_cnt_c = popcnt(sel_c);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s2_hit   <= 1'b0;
            s2_full  <= 1'b0;
            s2_empty <= 1'b0;
            s2_sel   <= '0;
            s2_mask  <= '0;
            s2_pos   <= '0;
            s2_cnt   <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv && s1_vld && !bus.i_flush) begin
            s2_hit   <= |sel_c;
            s2_full  <= &s1_stvld;
            s2_empty <= ~|s1_stvld;
            s2_sel   <= sel_c;
            s2_mask  <= mask_c;
            s2_pos   <= pos_c;
            s2_cnt   <= cnt_c;
            s2_err   <= sel_cnt_c > POS_W'(1);
        end
    end

    assign bus.o_vld     = s2_vld;
    assign bus.o_hit     = s2_hit;
    assign bus.o_full    = s2_full;
    assign bus.o_empty   = s2_empty;
    assign bus.o_sel     = s2_sel;
    assign bus.o_mask    = s2_mask;
    assign bus.o_pos     = s2_pos;
    assign bus.o_cnt     = s2_cnt;
    assign bus.o_err_dup = s2_err;

`ifndef SYNTHESIS
    a_vld_contig: assert property (@(posedge clk) disable iff (!arst_n)
        accept |-> ((bus.i_stcur_vld & (bus.i_stcur_vld + ENTRIES_N'(1))) == '0));

    a_sel_onehot: assert property (@(posedge clk) disable iff (!arst_n)
        (bus.o_vld && !bus.o_err_dup) |-> $onehot0(bus.o_sel));

    a_stall_stable: assert property (@(posedge clk) disable iff (!arst_n)
        (bus.o_vld && !bus.i_rdy && !bus.i_flush) |=>
        (bus.o_vld && $stable(bus.o_hit) && $stable(bus.o_full) && $stable(bus.o_empty) &&
         $stable(bus.o_sel) && $stable(bus.o_mask) && $stable(bus.o_pos) &&
         $stable(bus.o_cnt) && $stable(bus.o_err_dup)));
`endif
endmodule

// File: tb/tb_v_pipe_update_cmp_pl.sv
// Bench for v_pipe_update_cmp_pl: directed table cases, backpressure, flush and reset,
// then a randomized stream scored against a counting reference model.
module tb_v_pipe_update_cmp_pl;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int PW = $clog2(N + 1);
  localparam int RW = 4 + 2*N + 2*PW;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  v_pipe_update_cmp_pl_if #(.ENTRIES_N(N), .KEY_W(KW)) bus();

  v_pipe_update_cmp_pl #(.ENTRIES_N(N), .KEY_W(KW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  logic [RW-1:0] exp_q[$];
  int t_q[$];
  bit s_q[$];
  bit strict_lat = 1'b0;
  bit rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] pack(input logic hit, input logic full, input logic empty,
                                         input logic err, input logic [N-1:0] sel,
                                         input logic [N-1:0] mask, input logic [PW-1:0] pos,
                                         input logic [PW-1:0] cnt);
    return {hit, full, empty, err, sel, mask, pos, cnt};
  endfunction

  function automatic logic [RW-1:0] dut_out();
    return pack(bus.o_hit, bus.o_full, bus.o_empty, bus.o_err_dup, bus.o_sel, bus.o_mask,
                bus.o_pos, bus.o_cnt);
  endfunction

  function automatic logic [N-1:0] vmask(input int nv);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < nv; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Reference: count valid entries strictly better than / equal to the key.
  function automatic logic [RW-1:0] model(input bit bid, input logic [KW-1:0] key, input int nv,
                                          input logic [N*KW-1:0] keys);
    int hits, better, kv, kk;
    logic [N-1:0] sel, mask;
    hits = 0; better = 0; sel = '0; mask = '0;
    kk = int'(key);
    for (int i = 0; i < nv; i++) begin
      kv = int'(keys[i*KW +: KW]);
      if (kv == kk) begin
        hits++;
        sel[i] = 1'b1;
        mask[i] = 1'b1;
      end else if (bid ? (kv > kk) : (kv < kk)) begin
        better++;
        mask[i] = 1'b1;
      end
    end
    return pack(hits > 0, nv == N, nv == 0, hits > 1, sel, mask, PW'(better), PW'(nv));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    t_q.delete();
    s_q.delete();
  endtask

  task automatic send(input bit bid, input logic [KW-1:0] key, input logic [N-1:0] vld,
                      input logic [N*KW-1:0] keys, input logic [RW-1:0] exp);
    bit done;
    done = 1'b0;
    @(posedge clk); #2;
    bus.i_vld = 1'b1;
    bus.i_is_bid = bid;
    bus.i_key = key;
    bus.i_stcur_vld = vld;
    bus.i_stcur_keys = keys;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge clk);
      if (bus.o_rdy) begin
        exp_q.push_back(exp);
        t_q.push_back(cyc);
        s_q.push_back(strict_lat);
        n_acc++;
        done = 1'b1;
      end else begin
        @(posedge clk); #2;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got o_rdy=0 for 50 cycles expected accept");
    end
  endtask

  task automatic send_rand();
    bit bid;
    int nv;
    logic [KW-1:0] key;
    logic [N*KW-1:0] keys;
    bid = 1'($urandom_range(0, 1));
    nv = $urandom_range(0, N);
    key = KW'($urandom_range(0, 7));
    if ($urandom_range(0, 9) == 0) key = 8'hff;
    else if ($urandom_range(0, 9) == 0) key = 8'h00;
    for (int i = 0; i < N; i++) keys[i*KW +: KW] = KW'($urandom_range(0, 7));
    send(bid, key, vmask(nv), keys, model(bid, key, nv, keys));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      bus.i_vld = 1'b0;
    end
  endtask

  initial begin
    bus.i_rdy = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: pops on every result transfer and checks hold behaviour during stalls.
  initial begin
    logic [RW-1:0] prev_out;
    logic [RW-1:0] exp;
    bit prev_stall;
    int t;
    bit s;
    prev_stall = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold", dut_out(), prev_out);
          chk("stall_vld", bus.o_vld, 1);
        end
        if (bus.o_vld && bus.i_rdy) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_out: got result %h expected none", dut_out());
          end else begin
            exp = exp_q.pop_front();
            t = t_q.pop_front();
            s = s_q.pop_front();
            chk("result", dut_out(), exp);
            if (s) chk("latency", cyc - t, 2);
          end
        end
        prev_stall = bus.o_vld && !bus.i_rdy && !bus.i_flush;
        prev_out = dut_out();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.i_vld = 1'b0;
    bus.i_is_bid = 1'b0;
    bus.i_key = '0;
    bus.i_stcur_vld = '0;
    bus.i_stcur_keys = '0;
    bus.i_flush = 1'b0;
    arst_n = 1'b0;
    #12;
    chk("rst_out", dut_out(), '0);
    chk("rst_vld", bus.o_vld, 0);
    @(posedge clk); #2;
    arst_n = 1'b1;
    @(negedge clk);
    chk("rdy_idle", bus.o_rdy, 1);

    // Directed table cases with exact latency
    strict_lat = 1'b1;
    send(1'b1, 8'd20, 4'b0111, {8'd0, 8'd10, 8'd20, 8'd30},
         pack(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0011, 3'd1, 3'd3));
    send(1'b0, 8'd25, 4'b0111, {8'd5, 8'd30, 8'd20, 8'd10},
         pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 3'd2, 3'd3));
    send(1'b1, 8'd5, 4'b1111, {8'd10, 8'd20, 8'd30, 8'd40},
         pack(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 3'd4, 3'd4));
    send(1'b1, 8'd7, 4'b0000, {8'd7, 8'd7, 8'd7, 8'd7},
         pack(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 3'd0));
    send(1'b1, 8'd15, 4'b0011, {8'd15, 8'd15, 8'd15, 8'd15},
         pack(1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0011, 3'd0, 3'd2));
    idle(4);

    // Back-to-back stream with a three-cycle downstream stall
    strict_lat = 1'b0;
    base = n_acc;
    fork
      for (int j = 0; j < 8; j++) send_rand();
      begin
        wait (n_acc >= base + 3);
        @(posedge clk); #1;
        rdy_force = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("stall_rdy_low", bus.o_rdy, 0);
        chk("stall_outstanding", exp_q.size(), 2);
        rdy_force = 1'b1;
      end
    join
    idle(6);
    chk("stream_drained", exp_q.size(), 0);

    // Flush with both stages occupied
    rdy_force = 1'b0;
    idle(2);
    send_rand();
    send_rand();
    @(posedge clk); #2;
    bus.i_flush = 1'b1;
    bus.i_vld = 1'b1;
    @(negedge clk);
    chk("flush_rdy", bus.o_rdy, 0);
    #1;
    clear_sb();
    rdy_force = 1'b1;
    @(posedge clk); #2;
    bus.i_flush = 1'b0;
    bus.i_vld = 1'b0;
    @(negedge clk);
    chk("flush_vld", bus.o_vld, 0);
    chk("flush_rdy_back", bus.o_rdy, 1);
    strict_lat = 1'b1;
    send_rand();
    idle(4);

    // Asynchronous reset in the middle of traffic
    send_rand();
    send_rand();
    @(posedge clk); #2;
    bus.i_vld = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("arst_out", dut_out(), '0);
    chk("arst_vld", bus.o_vld, 0);
    clear_sb();
    repeat (2) @(posedge clk);
    #2;
    arst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_vld", bus.o_vld, 0);
    end
    send_rand();
    idle(4);

    // Randomized stream with random downstream backpressure
    strict_lat = 1'b0;
    rdy_rand = 1'b1;
    for (int j = 0; j < 60; j++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(negedge clk);
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
